// File: rtl/alu_sequencer.sv
// ALU control sequencer: decodes ALU class/funct into a registered ALU code and
// sequences a multi-cycle multiplier, stalling upstream while it runs.
module alu_sequencer #(
  parameter int unsigned MULTI_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid_in,
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] alu_ctrl,
  output logic       mul_start,
  output logic       stall,
  output logic       result_valid,
  output logic       illegal
);

  typedef enum logic [1:0] {
    StIdle,
    StMulRun,
    StMulDone
  } state_e;

  localparam logic [7:0] CntInit = 8'(MULTI_CYCLES - 1);
  localparam logic [3:0] CtrlAnd = 4'b0000;
  localparam logic [3:0] CtrlOr  = 4'b0001;
  localparam logic [3:0] CtrlAdd = 4'b0010;
  localparam logic [3:0] CtrlSub = 4'b0110;
  localparam logic [3:0] CtrlSlt = 4'b0111;
  localparam logic [3:0] CtrlMul = 4'b1000;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] alu_ctrl_q, alu_ctrl_d;
  logic       mul_start_q, mul_start_d;
  logic       stall_q, stall_d;
  logic       result_valid_q, result_valid_d;
  logic       illegal_q, illegal_d;

  logic [3:0] dec_ctrl;
  logic       dec_mul;
  logic       dec_illegal;

  // Unsupported R-type functs fall back to add and flag illegal.
  always_comb begin
    dec_ctrl    = CtrlAdd;
    dec_mul     = 1'b0;
    dec_illegal = 1'b0;
    unique case (alu_op)
      2'b00: dec_ctrl = CtrlAdd;
      2'b01: dec_ctrl = CtrlSub;
      2'b11: dec_ctrl = CtrlOr;
      2'b10: begin
        case (funct)
          6'b100000: dec_ctrl = CtrlAdd;
          6'b100010: dec_ctrl = CtrlSub;
          6'b100100: dec_ctrl = CtrlAnd;
          6'b100101: dec_ctrl = CtrlOr;
          6'b101010: dec_ctrl = CtrlSlt;
          6'b011000: begin
            dec_ctrl = CtrlMul;
            dec_mul  = 1'b1;
          end
          default: begin
            dec_ctrl    = CtrlAdd;
            dec_illegal = 1'b1;
          end
        endcase
      end
      default: dec_ctrl = CtrlAdd;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    alu_ctrl_d     = alu_ctrl_q;
    mul_start_d    = 1'b0;
    stall_d        = 1'b0;
    result_valid_d = 1'b0;
    illegal_d      = 1'b0;
    unique case (state_q)
      StIdle, StMulDone: begin
        state_d = StIdle;
        if (valid_in) begin
          alu_ctrl_d = dec_ctrl;
          if (dec_mul) begin
            state_d     = StMulRun;
            cnt_d       = CntInit;
            mul_start_d = 1'b1;
            stall_d     = 1'b1;
          end else begin
            result_valid_d = 1'b1;
            illegal_d      = dec_illegal;
          end
        end
      end
      StMulRun: begin
        // New instructions are ignored here; upstream is held by stall.
        if (cnt_q == 8'd0) begin
          state_d        = StMulDone;
          result_valid_d = 1'b1;
        end else begin
          cnt_d   = cnt_q - 8'd1;
          stall_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      cnt_q          <= 8'd0;
      alu_ctrl_q     <= 4'b0000;
      mul_start_q    <= 1'b0;
      stall_q        <= 1'b0;
      result_valid_q <= 1'b0;
      illegal_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      alu_ctrl_q     <= alu_ctrl_d;
      mul_start_q    <= mul_start_d;
      stall_q        <= stall_d;
      result_valid_q <= result_valid_d;
      illegal_q      <= illegal_d;
    end
  end

  assign alu_ctrl     = alu_ctrl_q;
  assign mul_start    = mul_start_q;
  assign stall        = stall_q;
  assign result_valid = result_valid_q;
  assign illegal      = illegal_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: one instance with an 8-cycle multiplier,
// one with a 1-cycle multiplier.
module tb_alu_sequencer;

  logic       clk;
  logic       rst;
  logic       valid_a, valid_b;
  logic [1:0] op_a, op_b;
  logic [5:0] funct_a, funct_b;
  logic [3:0] ctrl_a, ctrl_b;
  logic       ms_a, ms_b, stall_a, stall_b, rv_a, rv_b, ill_a, ill_b;

  int n_asserts = 0;
  int n_fail    = 0;

  alu_sequencer #(.MULTI_CYCLES(8)) dut_a (
    .clk          (clk),
    .rst          (rst),
    .valid_in     (valid_a),
    .alu_op       (op_a),
    .funct        (funct_a),
    .alu_ctrl     (ctrl_a),
    .mul_start    (ms_a),
    .stall        (stall_a),
    .result_valid (rv_a),
    .illegal      (ill_a)
  );

  alu_sequencer #(.MULTI_CYCLES(1)) dut_b (
    .clk          (clk),
    .rst          (rst),
    .valid_in     (valid_b),
    .alu_op       (op_b),
    .funct        (funct_b),
    .alu_ctrl     (ctrl_b),
    .mul_start    (ms_b),
    .stall        (stall_b),
    .result_valid (rv_b),
    .illegal      (ill_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [3:0] ctrl, input logic ms,
                       input logic st, input logic rv, input logic il);
    chk({tag, "_ctrl"}, ctrl_a, ctrl);
    chk({tag, "_mul_start"}, {3'b0, ms_a}, {3'b0, ms});
    chk({tag, "_stall"}, {3'b0, stall_a}, {3'b0, st});
    chk({tag, "_result_valid"}, {3'b0, rv_a}, {3'b0, rv});
    chk({tag, "_illegal"}, {3'b0, ill_a}, {3'b0, il});
  endtask

  logic [1:0] vec_op   [8];
  logic [5:0] vec_fn   [8];
  logic [3:0] vec_ctrl [8];
  logic       vec_ill  [8];
  logic       seen_rv;

  initial begin
    vec_op[0] = 2'b00; vec_fn[0] = 6'b000000; vec_ctrl[0] = 4'b0010; vec_ill[0] = 1'b0;
    vec_op[1] = 2'b01; vec_fn[1] = 6'b101010; vec_ctrl[1] = 4'b0110; vec_ill[1] = 1'b0;
    vec_op[2] = 2'b11; vec_fn[2] = 6'b011000; vec_ctrl[2] = 4'b0001; vec_ill[2] = 1'b0;
    vec_op[3] = 2'b10; vec_fn[3] = 6'b100000; vec_ctrl[3] = 4'b0010; vec_ill[3] = 1'b0;
    vec_op[4] = 2'b10; vec_fn[4] = 6'b100100; vec_ctrl[4] = 4'b0000; vec_ill[4] = 1'b0;
    vec_op[5] = 2'b10; vec_fn[5] = 6'b100101; vec_ctrl[5] = 4'b0001; vec_ill[5] = 1'b0;
    vec_op[6] = 2'b10; vec_fn[6] = 6'b101010; vec_ctrl[6] = 4'b0111; vec_ill[6] = 1'b0;
    vec_op[7] = 2'b10; vec_fn[7] = 6'b111111; vec_ctrl[7] = 4'b0010; vec_ill[7] = 1'b1;

    rst = 1'b1;
    valid_a = 1'b0; op_a = 2'b00; funct_a = 6'b0;
    valid_b = 1'b0; op_b = 2'b00; funct_b = 6'b0;
    #1;
    chk_a("reset_async", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    chk_a("reset_clocked", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_b_ctrl", ctrl_b, 4'b0000);
    rst = 1'b0;

    // R-type sub, then idle cycle: pulse must not repeat, ctrl must hold.
    valid_a = 1'b1; op_a = 2'b10; funct_a = 6'b100010;
    tick();
    chk_a("rtype_sub", 4'b0110, 1'b0, 1'b0, 1'b1, 1'b0);
    valid_a = 1'b0;
    tick();
    chk_a("idle_hold", 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      valid_a = 1'b1; op_a = vec_op[i]; funct_a = vec_fn[i];
      tick();
      chk_a($sformatf("decode%0d", i), vec_ctrl[i], 1'b0, 1'b0, 1'b1, vec_ill[i]);
    end
    valid_a = 1'b0;
    tick();
    chk_a("after_illegal", 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);

    // Multiply, with an add held on the inputs through the stall.
    valid_a = 1'b1; op_a = 2'b10; funct_a = 6'b011000;
    tick();
    chk_a("mul_c1", 4'b1000, 1'b1, 1'b1, 1'b0, 1'b0);
    op_a = 2'b00; funct_a = 6'b000000;
    for (int c = 2; c <= 8; c++) begin
      tick();
      chk_a($sformatf("mul_c%0d", c), 4'b1000, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    tick();
    chk_a("mul_c9", 4'b1000, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk_a("mul_c10_add", 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0);
    valid_a = 1'b0;
    tick();
    chk_a("mul_c11", 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);

    // Single-cycle multiplier instance.
    valid_b = 1'b1; op_b = 2'b10; funct_b = 6'b011000;
    tick();
    valid_b = 1'b0;
    chk("m1_c1_stall", {3'b0, stall_b}, 4'd1);
    chk("m1_c1_start", {3'b0, ms_b}, 4'd1);
    chk("m1_c1_rv", {3'b0, rv_b}, 4'd0);
    tick();
    chk("m1_c2_stall", {3'b0, stall_b}, 4'd0);
    chk("m1_c2_rv", {3'b0, rv_b}, 4'd1);
    chk("m1_c2_ctrl", ctrl_b, 4'b1000);
    tick();
    chk("m1_c3_rv", {3'b0, rv_b}, 4'd0);

    // Abort a multiply with reset between edges.
    valid_a = 1'b1; op_a = 2'b10; funct_a = 6'b011000;
    tick();
    valid_a = 1'b0;
    tick();
    tick();
    tick();
    chk_a("abort_c4", 4'b1000, 1'b0, 1'b1, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_a("abort_async", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    seen_rv = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (rv_a || stall_a) seen_rv = 1'b1;
    end
    chk("abort_no_result", {3'b0, seen_rv}, 4'd0);
    valid_a = 1'b1; op_a = 2'b01; funct_a = 6'b000000;
    tick();
    valid_a = 1'b0;
    chk_a("after_abort_sub", 4'b0110, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
